line_painter: RTL and testbench
===============================

# line_painter

Draw-side line renderer for the double-buffered line buffer. On every buffer swap it clears the off-screen line to a background colour, then renders a stream of horizontal spans (solid or diagonal-gradient) into it, writing `LANES` pixels per cycle with per-lane write enables. It replaces the fixed combinational test pattern on the `addr_off_draw`/`we_off_draw`/`colour_off_draw` port of `double_buffer`. It is parametrised in lane count, line width and coordinate width.

## Interface
- `LANES`, 16, pixels per line-buffer word (power of two)
- `LINE_W`, 1280, pixels per line (multiple of `LANES`); `WORDS = LINE_W/LANES`
- `CORDW`, 11, coordinate width
- `ADDRW`, `$clog2(WORDS)`, line-buffer word address width
- `clk_pix` in 1: the single clock
- `rst_pix` in 1: reset, synchronous, active-high
- `line_start` in 1: one-cycle pulse, off buffer has just swapped
- `line_y` in CORDW: line number being drawn; sampled on `line_start`
- `bg_colour` in 8: clear colour; sampled on `line_start`
- `span_valid` in 1 / `span_ready` out 1: span handshake
- `span_x0`, `span_x1` in CORDW: span is [x0, x1), exclusive end
- `span_colour` in 8: base palette index
- `span_mode` in 1: 0 = solid, 1 = gradient
- `span_last` in 1: final span for this line
- `addr_off_draw` out ADDRW: word address
- `we_off_draw` out LANES: per-lane write enable; bit i = pixel `addr*LANES+i`
- `colour_off_draw` out 8*LANES: lane i in bits [8i+7:8i]
- `busy` out 1: high from `line_start` until the line is complete
- `overrun` out 1: one-cycle pulse, `line_start` arrived while busy

## Operation
- States: IDLE, CLEAR, WAIT_SPAN, SPAN.
- IDLE: `busy`=0, `span_ready`=0. `line_start` -> CLEAR with word counter 0.
- CLEAR: one word per cycle, addr 0..WORDS-1, `we`=all ones, every lane `bg_colour`. After word WORDS-1 -> WAIT_SPAN.
- WAIT_SPAN: `span_ready`=1. On accept, latch the span. x1 is clamped to LINE_W. If clamped x1 <= x0 there are no writes: go to IDLE if `span_last`, else stay in WAIT_SPAN. Otherwise go to SPAN at word x0/LANES.
- SPAN: one word per cycle, from x0/LANES to (x1-1)/LANES. Lane i is enabled iff pixel p = word*LANES+i satisfies x0 <= p < x1.
  - Solid: lane colour is `span_colour`.
  - Gradient: lane colour is `(span_colour + p[7:0] + line_y[7:0]) mod 256`, 8-bit wrap.
  - After the last word: IDLE if the span was `span_last`, else WAIT_SPAN.
- `line_start` in any non-IDLE state:
  - `overrun` pulses.
  - Any latched span is discarded.
  - `line_y` and `bg_colour` are re-sampled.
  - Restart CLEAR at word 0.
- When no write is issued, `we_off_draw`=0. `addr` and `colour` are don't-care but are held.

## Timing
- All outputs are registered.
- Reset (synchronous): state IDLE; `addr`=0, `we`=0, `colour`=0, `busy`=0, `span_ready`=0, `overrun`=0.
- `line_start` sampled at edge N:
  - `busy`=1 from cycle N+1.
  - First clear write (addr 0) is valid during cycle N+1.
  - Last clear write is valid during cycle N+WORDS.
  - `span_ready`=1 from cycle N+WORDS+1.
- Span accepted at edge M: its first write is valid in cycle M+1, and `span_ready`=0 during its writes. A k-word span occupies cycles M+1..M+k, and `span_ready` is high again in cycle M+k+1.
- After the `span_last` span's final write, `busy`=0 in the next cycle.
- `overrun` is high for exactly the cycle after the offending edge.
- A clear takes exactly WORDS cycles. There are no bubbles between words.

## Structure
- `line_painter_pkg`: state enum, `span_mode_t` (SOLID, GRADIENT), and `WORDS`/`ADDRW` localparam helpers.
- Sub-module `span_mask`: combinational. Takes word address, x0 and x1, and returns a LANES-bit enable. It is reused for clamping and range checks.

## Test plan
All scenarios use LANES=16 and LINE_W=1280 (WORDS=80).
- Reset: hold `rst_pix` mid-SPAN for 1 cycle -> next cycle `we`=0, `busy`=0, `span_ready`=0, `addr`=0.
- Clear: `line_start`, `bg_colour`=0x20 -> 80 consecutive writes, addr 0..79, `we`=0xFFFF, all lanes 0x20. `span_ready` rises in the cycle after addr 79.
- Solid span: x0=5, x1=37, colour 0x07, last -> writes:
  - addr 0, `we`=0xFFE0
  - addr 1, `we`=0xFFFF
  - addr 2, `we`=0x001F
  - all lanes 0x07; `busy` falls the next cycle.
- Gradient plus clamp:
  - `line_y`=3, colour 0x10, x0=0, x1=16 -> addr 0, `we`=0xFFFF, lane i = 0x13+i.
  - Then x0=1270, x1=2000 -> addr 79, `we`=0xFFC0.
- Empty span: x0=x1=100, last -> no write cycles, IDLE next cycle.
- Overrun: `line_start` again when clear addr=40 -> `overrun` pulses once, next write is addr 0 with the new `bg_colour`, and 80 full clear writes follow.

Source files
------------

// File: rtl/line_painter_pkg.sv
// line_painter_pkg: shared types and sizing helpers for the line painter.
//   state_t     - draw FSM states
//   span_mode_t - span fill mode (solid / diagonal gradient)
//   words_of    - line-buffer words per line
//   addrw_of    - word-address width (at least 1 bit)
package line_painter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_SPAN,
        ST_SPAN
    } state_t;

    typedef enum logic {
        SOLID    = 1'b0,
        GRADIENT = 1'b1
    } span_mode_t;

    function automatic int words_of(input int line_w, input int lanes);
        return line_w / lanes;
    endfunction

    function automatic int addrw_of(input int line_w, input int lanes);
        int w;
        w = $clog2(line_w / lanes);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/line_painter_span_mask.sv
// span_mask: combinational lane-enable generator.
//   word - line-buffer word address
//   x0   - first pixel of the span (inclusive)
//   x1   - end pixel of the span (exclusive, already clamped)
//   mask - bit i set iff pixel word*LANES+i lies in [x0, x1)
module span_mask #(
    parameter int LANES = 16,
    parameter int ADDRW = 7,
    parameter int XW    = 12
) (
    input  logic [ADDRW-1:0] word,
    input  logic [XW-1:0]    x0,
    input  logic [XW-1:0]    x1,
    output logic [LANES-1:0] mask
);

    localparam int LGL = $clog2(LANES);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            mask[i] = (((32'(word) << LGL) | 32'(i)) >= 32'(x0)) &&
                      (((32'(word) << LGL) | 32'(i)) <  32'(x1));
        end
    end

endmodule

// File: rtl/line_painter.sv
// line_painter: draw-side renderer for the off-screen half of the line buffer.
// On line_start it clears the line to bg_colour, then paints accepted spans
// (solid or gradient), LANES pixels per cycle with per-lane write enables.
//   clk_pix, rst_pix          - clock, synchronous active-high reset
//   line_start, line_y,
//   bg_colour                 - buffer swap pulse and per-line parameters
//   span_valid/span_ready     - span handshake
//   span_x0/x1/colour/mode/last - span description, [x0, x1)
//   addr_off_draw, we_off_draw,
//   colour_off_draw           - line-buffer write port (registered)
//   busy, overrun             - line in progress; line_start while busy
module line_painter
    import line_painter_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int LINE_W = 1280,
    parameter int CORDW  = 11,
    parameter int ADDRW  = addrw_of(LINE_W, LANES)
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    input  logic                 line_start,
    input  logic [CORDW-1:0]     line_y,
    input  logic [7:0]           bg_colour,
    input  logic                 span_valid,
    output logic                 span_ready,
    input  logic [CORDW-1:0]     span_x0,
    input  logic [CORDW-1:0]     span_x1,
    input  logic [7:0]           span_colour,
    input  logic                 span_mode,
    input  logic                 span_last,
    output logic [ADDRW-1:0]     addr_off_draw,
    output logic [LANES-1:0]     we_off_draw,
    output logic [8*LANES-1:0]   colour_off_draw,
    output logic                 busy,
    output logic                 overrun
);

    localparam int WORDS = words_of(LINE_W, LANES);
    localparam int LGL   = $clog2(LANES);
    localparam int XW    = CORDW + 1;
    localparam logic [XW-1:0]    LINE_END  = XW'(LINE_W);
    localparam logic [ADDRW-1:0] LAST_WORD = ADDRW'(WORDS - 1);

    state_t             state_q, state_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [LANES-1:0]   we_q, we_d;
    logic [8*LANES-1:0] colour_q, colour_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               overrun_q, overrun_d;

    // Latched span and line parameters
    logic [XW-1:0]      x0_q, x0_d;
    logic [XW-1:0]      x1_q, x1_d;
    logic [ADDRW-1:0]   end_word_q, end_word_d;
    logic [7:0]         scol_q, scol_d;
    span_mode_t         mode_q, mode_d;
    logic               last_q, last_d;
    logic [7:0]         y_q, y_d;

    // Incoming span, clamped to the line
    logic [XW-1:0]      in_x0, in_x1c, in_x1m1;
    logic               in_empty;
    logic [ADDRW-1:0]   in_first_word, in_end_word;

    assign in_x0         = {1'b0, span_x0};
    assign in_x1c        = ({1'b0, span_x1} > LINE_END) ? LINE_END : {1'b0, span_x1};
    assign in_x1m1       = in_x1c - XW'(1);
    assign in_empty      = (in_x1c <= in_x0);
    assign in_first_word = ADDRW'(in_x0 >> LGL);
    assign in_end_word   = ADDRW'(in_x1m1 >> LGL);

    // One mask/colour path serves both the first word (straight from the
    // handshake inputs) and the following words (from the latched span).
    logic               use_in;
    logic [ADDRW-1:0]   paint_word;
    logic [XW-1:0]      paint_x0, paint_x1;
    logic [7:0]         paint_base;
    span_mode_t         paint_mode;
    logic [LANES-1:0]   paint_mask;
    logic [8*LANES-1:0] paint_colour;

    assign use_in     = (state_q == ST_WAIT_SPAN);
    assign paint_word = use_in ? in_first_word : addr_q + 1'b1;
    assign paint_x0   = use_in ? in_x0 : x0_q;
    assign paint_x1   = use_in ? in_x1c : x1_q;
    assign paint_base = use_in ? span_colour : scol_q;
    assign paint_mode = use_in ? span_mode_t'(span_mode) : mode_q;

    span_mask #(
        .LANES (LANES),
        .ADDRW (ADDRW),
        .XW    (XW)
    ) u_span_mask (
        .word (paint_word),
        .x0   (paint_x0),
        .x1   (paint_x1),
        .mask (paint_mask)
    );

    always_comb begin
        paint_colour = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (paint_mode == GRADIENT) begin
                paint_colour[8*i +: 8] = paint_base
                                       + 8'((32'(paint_word) << LGL) | 32'(i))
                                       + y_q;
            end else begin
                paint_colour[8*i +: 8] = paint_base;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = '0;
        colour_d   = colour_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        overrun_d  = 1'b0;
        x0_d       = x0_q;
        x1_d       = x1_q;
        end_word_d = end_word_q;
        scol_d     = scol_q;
        mode_d     = mode_q;
        last_d     = last_q;
        y_d        = y_q;

        if (line_start) begin
            overrun_d = (state_q != ST_IDLE);
            state_d   = ST_CLEAR;
            addr_d    = '0;
            we_d      = '1;
            colour_d  = {LANES{bg_colour}};
            busy_d    = 1'b1;
            ready_d   = 1'b0;
            last_d    = 1'b0;
            y_d       = line_y[7:0];
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CLEAR: begin
                    if (addr_q == LAST_WORD) begin
                        state_d = ST_WAIT_SPAN;
                        ready_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        we_d   = '1;
                    end
                end
                ST_WAIT_SPAN: begin
                    if (span_valid) begin
                        if (in_empty) begin
                            if (span_last) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                ready_d = 1'b0;
                            end
                        end else begin
                            state_d    = ST_SPAN;
                            ready_d    = 1'b0;
                            addr_d     = in_first_word;
                            we_d       = paint_mask;
                            colour_d   = paint_colour;
                            x0_d       = in_x0;
                            x1_d       = in_x1c;
                            end_word_d = in_end_word;
                            scol_d     = span_colour;
                            mode_d     = span_mode_t'(span_mode);
                            last_d     = span_last;
                        end
                    end
                end
                ST_SPAN: begin
                    if (addr_q == end_word_q) begin
                        state_d = last_q ? ST_IDLE : ST_WAIT_SPAN;
                        ready_d = !last_q;
                        busy_d  = !last_q;
                    end else begin
                        addr_d   = addr_q + 1'b1;
                        we_d     = paint_mask;
                        colour_d = paint_colour;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= '0;
            colour_q   <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            end_word_q <= '0;
            scol_q     <= '0;
            mode_q     <= SOLID;
            last_q     <= 1'b0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            colour_q   <= colour_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            end_word_q <= end_word_d;
            scol_q     <= scol_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            y_q        <= y_d;
        end
    end

    assign addr_off_draw   = addr_q;
    assign we_off_draw     = we_q;
    assign colour_off_draw = colour_q;
    assign busy            = busy_q;
    assign span_ready      = ready_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_line_painter.sv
module tb_line_painter;

    logic         clk_pix = 1'b0;
    logic         rst_pix;
    logic         line_start;
    logic [10:0]  line_y;
    logic [7:0]   bg_colour;
    logic         span_valid;
    logic         span_ready;
    logic [10:0]  span_x0, span_x1;
    logic [7:0]   span_colour;
    logic         span_mode;
    logic         span_last;
    logic [6:0]   addr_off_draw;
    logic [15:0]  we_off_draw;
    logic [127:0] colour_off_draw;
    logic         busy;
    logic         overrun;

    line_painter #(
        .LANES  (16),
        .LINE_W (1280),
        .CORDW  (11)
    ) dut (
        .clk_pix         (clk_pix),
        .rst_pix         (rst_pix),
        .line_start      (line_start),
        .line_y          (line_y),
        .bg_colour       (bg_colour),
        .span_valid      (span_valid),
        .span_ready      (span_ready),
        .span_x0         (span_x0),
        .span_x1         (span_x1),
        .span_colour     (span_colour),
        .span_mode       (span_mode),
        .span_last       (span_last),
        .addr_off_draw   (addr_off_draw),
        .we_off_draw     (we_off_draw),
        .colour_off_draw (colour_off_draw),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [6:0]   addr;
        logic [15:0]  we;
        logic [127:0] col;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] c);
        return {16{c}};
    endfunction

    task automatic push_w(input logic [6:0] a, input logic [15:0] w, input logic [127:0] c);
        wr_t e;
        e.addr = a;
        e.we   = w;
        e.col  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input logic [7:0] bg, input int n);
        for (int a = 0; a < n; a++) push_w(7'(a), 16'hFFFF, fill(bg));
    endtask

    // Monitor: every write the DUT presents must match the head of the queue
    initial begin
        wr_t          e;
        logic [127:0] m;
        forever begin
            @(negedge clk_pix);
            if (mon_en && we_off_draw !== 16'h0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d we=%h, expected no write",
                             addr_off_draw, we_off_draw);
                end else begin
                    e = exp_q.pop_front();
                    m = '0;
                    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{e.we[i]}};
                    if (addr_off_draw !== e.addr || we_off_draw !== e.we ||
                        (colour_off_draw & m) !== (e.col & m)) begin
                        failures++;
                        $display("FAIL write: got addr=%0d we=%h col=%h expected addr=%0d we=%h col=%h",
                                 addr_off_draw, we_off_draw, colour_off_draw & m,
                                 e.addr, e.we, e.col & m);
                    end
                end
            end
        end
    end

    // Called at posedge+1; drives a one-cycle line_start.
    task automatic pulse(input logic [10:0] y, input logic [7:0] bg);
        line_y     = y;
        bg_colour  = bg;
        line_start = 1'b1;
        @(posedge clk_pix);
        #1;
        line_start = 1'b0;
    endtask

    // Counts not-ready cycles (sampled at negedge), then realigns to posedge+1.
    task automatic wait_ready(input string name, input int expected);
        int n = 0;
        forever begin
            @(negedge clk_pix);
            if (span_ready === 1'b1) break;
            n++;
            if (n > 300) break;
        end
        check(name, 128'(n), 128'(expected));
        @(posedge clk_pix);
        #1;
    endtask

    // Called at posedge+1 while span_ready is high; span accepted on next edge.
    task automatic send_span(input logic [10:0] x0, input logic [10:0] x1,
                             input logic [7:0] c, input logic md, input logic lst);
        span_x0     = x0;
        span_x1     = x1;
        span_colour = c;
        span_mode   = md;
        span_last   = lst;
        span_valid  = 1'b1;
        @(posedge clk_pix);
        #1;
        span_valid  = 1'b0;
    endtask

    // Counts busy cycles after a span_last acceptance, then realigns.
    task automatic wait_idle(input string name, input int expected);
        int n = 0;
        forever begin
            @(negedge clk_pix);
            if (busy === 1'b0) break;
            n++;
            if (n > 300) break;
        end
        check(name, 128'(n), 128'(expected));
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        logic [127:0] c;
        rst_pix     = 1'b1;
        line_start  = 1'b0;
        line_y      = '0;
        bg_colour   = '0;
        span_valid  = 1'b0;
        span_x0     = '0;
        span_x1     = '0;
        span_colour = '0;
        span_mode   = 1'b0;
        span_last   = 1'b0;

        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix);
        check("rst_we",      128'(we_off_draw),     128'(0));
        check("rst_busy",    128'(busy),            128'(0));
        check("rst_ready",   128'(span_ready),      128'(0));
        check("rst_overrun", 128'(overrun),         128'(0));
        check("rst_addr",    128'(addr_off_draw),   128'(0));
        check("rst_colour",  colour_off_draw,       128'(0));
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        mon_en  = 1'b1;

        // Clear to 0x20, then a solid span over three words
        push_clear(8'h20, 80);
        pulse(11'd0, 8'h20);
        @(negedge clk_pix);
        check("clear_busy",    128'(busy),    128'(1));
        check("clear_overrun", 128'(overrun), 128'(0));
        wait_ready("clear_ready_delay", 79);

        push_w(7'd0, 16'hFFE0, fill(8'h07));
        push_w(7'd1, 16'hFFFF, fill(8'h07));
        push_w(7'd2, 16'h001F, fill(8'h07));
        send_span(11'd5, 11'd37, 8'h07, 1'b0, 1'b1);
        wait_idle("solid_busy_len", 3);
        check("solid_ready_after", 128'(span_ready), 128'(0));

        // Gradient spans, second one clamped to the line end
        push_clear(8'h55, 80);
        pulse(11'd3, 8'h55);
        wait_ready("grad_clear_ready", 80);
        for (int i = 0; i < 16; i++) c[8*i +: 8] = 8'(8'h13 + i);
        push_w(7'd0, 16'hFFFF, c);
        send_span(11'd0, 11'd16, 8'h10, 1'b1, 1'b0);
        wait_ready("grad_ready_again", 1);
        for (int i = 0; i < 16; i++) c[8*i +: 8] = 8'(8'h03 + i);
        push_w(7'd79, 16'hFFC0, c);
        send_span(11'd1270, 11'd2000, 8'h10, 1'b1, 1'b1);
        wait_idle("clamp_busy_len", 1);

        // Empty spans: reversed (not last) keeps waiting; x0==x1 last ends line
        push_clear(8'h01, 80);
        pulse(11'd0, 8'h01);
        wait_ready("empty_clear_ready", 80);
        send_span(11'd200, 11'd100, 8'hAA, 1'b0, 1'b0);
        @(negedge clk_pix);
        check("empty_nl_ready", 128'(span_ready), 128'(1));
        check("empty_nl_busy",  128'(busy),       128'(1));
        @(posedge clk_pix);
        #1;
        send_span(11'd100, 11'd100, 8'hAA, 1'b0, 1'b1);
        @(negedge clk_pix);
        check("empty_last_busy",  128'(busy),       128'(0));
        check("empty_last_ready", 128'(span_ready), 128'(0));
        @(posedge clk_pix);
        #1;

        // Overrun: second line_start while clear shows addr 40
        push_clear(8'h33, 41);
        push_clear(8'h44, 80);
        pulse(11'd0, 8'h33);
        repeat (40) @(posedge clk_pix);
        #1;
        check("ovr_addr_before", 128'(addr_off_draw), 128'(40));
        pulse(11'd0, 8'h44);
        @(negedge clk_pix);
        check("ovr_pulse", 128'(overrun), 128'(1));
        check("ovr_busy",  128'(busy),    128'(1));
        @(negedge clk_pix);
        check("ovr_pulse_end", 128'(overrun), 128'(0));
        wait_ready("ovr_clear_ready", 78);

        // Reset during a long span
        push_w(7'd0, 16'hFFFF, fill(8'h5A));
        push_w(7'd1, 16'hFFFF, fill(8'h5A));
        send_span(11'd0, 11'd1280, 8'h5A, 1'b0, 1'b1);
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b1;
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        @(negedge clk_pix);
        check("span_rst_we",    128'(we_off_draw),   128'(0));
        check("span_rst_busy",  128'(busy),          128'(0));
        check("span_rst_ready", 128'(span_ready),    128'(0));
        check("span_rst_addr",  128'(addr_off_draw), 128'(0));

        repeat (5) @(negedge clk_pix);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
